// File: rtl/simd_bram_pkg.sv
// Shared types and defaults for the SIMD block-RAM register file.
package simd_bram_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    localparam logic [31:0] DEF_IDLE_WORD = 32'd399;
    localparam logic [31:0] DEF_OOR_WORD  = 32'd199;

    function automatic int unsigned BYTES_OF(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/simd_bram_rd_pipe.sv
// Read-response pipeline: READ_LAT-deep shift of {valid, oor, perr, data}.
module simd_bram_rd_pipe #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       READ_LAT  = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic              in_oor,
    input  logic              in_perr,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic              oor,
    output logic              perr,
    output logic [DATA_W-1:0] dout
);

    logic [READ_LAT-1:0] v_q, o_q, p_q;
    logic [DATA_W-1:0]   d_q [READ_LAT];

    // Flags and data are masked at entry so an empty slot always shows IDLE_WORD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q <= '0;
            o_q <= '0;
            p_q <= '0;
            for (int i = 0; i < READ_LAT; i++) d_q[i] <= IDLE_WORD;
        end else begin
            v_q[0] <= in_valid;
            o_q[0] <= in_valid & in_oor;
            p_q[0] <= in_valid & in_perr;
            d_q[0] <= in_valid ? in_data : IDLE_WORD;
            for (int i = 1; i < READ_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                o_q[i] <= o_q[i-1];
                p_q[i] <= p_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign valid = v_q[READ_LAT-1];
    assign oor   = o_q[READ_LAT-1];
    assign perr  = p_q[READ_LAT-1];
    assign dout  = d_q[READ_LAT-1];

endmodule

// File: rtl/simd_bram_rf_dp.sv
// Dual-port register file for operand/result matrices with clear engine.
// Optional per-byte parity storage when SIMD_BRAM_PARITY_EN is defined.
module simd_bram_rf_dp
    import simd_bram_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 64,
    parameter int unsigned       ADDR_W     = 13,
    parameter int unsigned       READ_LAT   = 2,
    parameter int unsigned       READ_FIRST = 1,
    parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(DEF_IDLE_WORD),
    parameter logic [DATA_W-1:0] OOR_WORD   = DATA_W'(DEF_OOR_WORD)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                a_en,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    output logic                a_valid,
    output logic                a_oor,
    input  logic                b_en,
    input  logic [DATA_W/8-1:0] b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_din,
    output logic [DATA_W-1:0]   b_dout,
    output logic                b_valid,
    output logic                b_oor,
    output logic                b_ready,
    input  logic                clr_start,
    input  logic [ADDR_W-1:0]   clr_base,
    input  logic [ADDR_W-1:0]   clr_len,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [1:0]          perr
);

    localparam int unsigned       BYTES     = BYTES_OF(DATA_W);
    localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_t        clr_state;
    logic [ADDR_W-1:0] clr_addr, clr_rem;

    logic              a_in, b_in, clr_in;
    logic [IDX_W-1:0]  a_idx, b_idx, clr_idx, bw_idx;
    logic [BYTES-1:0]  a_wr_we, b_wr_we;
    logic [DATA_W-1:0] bw_data, a_old, b_old, a_rd_data, b_rd_data;
    logic              b_acc, a_rd, b_rd, a_perr_in, b_perr_in, a_pe, b_pe;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [BYTES-1:0]  be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BYTES; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    assign a_in    = {1'b0, a_addr}   < DEPTH_X;
    assign b_in    = {1'b0, b_addr}   < DEPTH_X;
    assign clr_in  = {1'b0, clr_addr} < DEPTH_X;
    assign a_idx   = a_addr[IDX_W-1:0];
    assign b_idx   = b_addr[IDX_W-1:0];
    assign clr_idx = clr_addr[IDX_W-1:0];

    // The clear engine borrows the port B write slot while busy.
    always_comb begin
        b_acc   = b_en && !clr_busy;
        a_wr_we = (a_en && a_in) ? a_we : '0;
        b_wr_we = (b_acc && b_in) ? b_we : '0;
        bw_idx  = b_idx;
        bw_data = b_din;
        if (clr_busy) begin
            b_wr_we = clr_in ? '1 : '0;
            bw_idx  = clr_idx;
            bw_data = '0;
        end
    end

    // Port A is applied last so it wins on bytes both sources enable.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < BYTES; i++) begin
            if (b_wr_we[i]) mem[bw_idx][i*8 +: 8] <= bw_data[i*8 +: 8];
            if (a_wr_we[i]) mem[a_idx][i*8 +: 8]  <= a_din[i*8 +: 8];
        end
    end

    assign a_old = mem[a_idx];
    assign b_old = mem[b_idx];
    assign a_rd  = a_en  && (a_we == '0);
    assign b_rd  = b_acc && (b_we == '0);

    always_comb begin
        a_rd_data = OOR_WORD;
        b_rd_data = OOR_WORD;
        if (a_in) a_rd_data = (READ_FIRST != 0) ? a_old : merge_bytes(a_old, a_din, a_we);
        if (b_in) b_rd_data = (READ_FIRST != 0) ? b_old : merge_bytes(b_old, b_din, b_we);
    end

`ifdef SIMD_BRAM_PARITY_EN
    logic [BYTES-1:0] par [DEPTH];

    function automatic logic [BYTES-1:0] par_of(input logic [DATA_W-1:0] w);
        logic [BYTES-1:0] p;
        for (int i = 0; i < BYTES; i++) p[i] = ^w[i*8 +: 8];
        return p;
    endfunction

    always_ff @(posedge CLK) begin
        for (int i = 0; i < BYTES; i++) begin
            if (b_wr_we[i]) par[bw_idx][i] <= ^bw_data[i*8 +: 8];
            if (a_wr_we[i]) par[a_idx][i]  <= ^a_din[i*8 +: 8];
        end
    end

    assign a_perr_in = a_in && (par_of(a_old) != par[a_idx]);
    assign b_perr_in = b_in && (par_of(b_old) != par[b_idx]);
`else
    assign a_perr_in = 1'b0;
    assign b_perr_in = 1'b0;
`endif

    simd_bram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT), .IDLE_WORD(IDLE_WORD)) u_pipe_a (
        .CLK(CLK), .RST(RST),
        .in_valid(a_rd), .in_oor(!a_in), .in_perr(a_perr_in), .in_data(a_rd_data),
        .valid(a_valid), .oor(a_oor), .perr(a_pe), .dout(a_dout)
    );

    simd_bram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT), .IDLE_WORD(IDLE_WORD)) u_pipe_b (
        .CLK(CLK), .RST(RST),
        .in_valid(b_rd), .in_oor(!b_in), .in_perr(b_perr_in), .in_data(b_rd_data),
        .valid(b_valid), .oor(b_oor), .perr(b_pe), .dout(b_dout)
    );

    assign perr = {b_pe, a_pe};

    // Clear engine: one word per cycle, wrapping at DEPTH-1; out-of-range words just burn a cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_state <= CLR_IDLE;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            b_ready   <= 1'b1;
            clr_addr  <= '0;
            clr_rem   <= '0;
        end else begin
            clr_done <= 1'b0;
            unique case (clr_state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        if (clr_len != '0) begin
                            clr_state <= CLR_RUN;
                            clr_busy  <= 1'b1;
                            b_ready   <= 1'b0;
                            clr_addr  <= clr_base;
                            clr_rem   <= clr_len;
                        end else begin
                            clr_state <= CLR_DONE;
                            clr_done  <= 1'b1;
                        end
                    end
                end
                CLR_RUN: begin
                    clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + ADDR_W'(1);
                    clr_rem  <= clr_rem - ADDR_W'(1);
                    if (clr_rem == ADDR_W'(1)) begin
                        clr_state <= CLR_DONE;
                        clr_busy  <= 1'b0;
                        b_ready   <= 1'b1;
                        clr_done  <= 1'b1;
                    end
                end
                CLR_DONE: clr_state <= CLR_IDLE;
                default:  clr_state <= CLR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_bram_rf_dp.sv
// Self-checking bench: random and directed traffic against a word-level memory model.
module tb_simd_bram_rf_dp;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned READ_LAT = 2;
    localparam logic [31:0] IDLE_W   = 32'd399;
    localparam logic [31:0] OOR_W    = 32'd199;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        a_en, b_en, a_valid, b_valid, a_oor, b_oor, b_ready;
    logic [3:0]  a_we, b_we;
    logic [12:0] a_addr, b_addr, clr_base, clr_len;
    logic [31:0] a_din, b_din, a_dout, b_dout;
    logic        clr_start, clr_busy, clr_done;
    logic [1:0]  perr;

    simd_bram_rf_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT),
                      .READ_FIRST(1), .IDLE_WORD(IDLE_W), .OOR_WORD(OOR_W)) dut (
        .CLK(CLK), .RST(RST),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_valid(a_valid), .a_oor(a_oor),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout), .b_valid(b_valid), .b_oor(b_oor), .b_ready(b_ready),
        .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len),
        .clr_busy(clr_busy), .clr_done(clr_done), .perr(perr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v;
        logic        o;
        logic        p;
        logic [31:0] d;
    } exp_t;

    localparam exp_t IDLE_E = '{v: 1'b0, o: 1'b0, p: 1'b0, d: 32'd399};

    exp_t        qa[$], qb[$];
    logic [31:0] mdl [DEPTH];
    logic [3:0]  bad [DEPTH];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // Expected response of one port request, from the model before this cycle's writes.
    function automatic exp_t resp(input logic en, input logic [3:0] we, input logic [12:0] addr);
        exp_t e;
        e = IDLE_E;
        if (en && we == 4'b0) begin
            e.v = 1'b1;
            if (addr >= DEPTH) begin
                e.o = 1'b1;
                e.d = OOR_W;
            end else begin
                e.p = |bad[addr];
                e.d = mdl[addr];
            end
        end
        return e;
    endfunction

    task automatic model_write(input logic en, input logic [3:0] we, input logic [12:0] addr,
                               input logic [31:0] din);
        if (en && addr < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mdl[addr][i*8 +: 8] = din[i*8 +: 8];
                    bad[addr][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic set_idle();
        a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
        clr_start = 0; clr_base = 0; clr_len = 0;
    endtask

    task automatic reset_queues();
        qa.delete();
        qb.delete();
        for (int i = 0; i < int'(READ_LAT) - 1; i++) begin
            qa.push_back(IDLE_E);
            qb.push_back(IDLE_E);
        end
    endtask

    // One clock with the currently driven requests; compares both ports every cycle.
    task automatic tick();
        exp_t ea, eb;
        qa.push_back(resp(a_en, a_we, a_addr));
        qb.push_back(resp(b_en, b_we, b_addr));
        model_write(b_en, b_we, b_addr, b_din);
        model_write(a_en, a_we, a_addr, a_din);
        @(posedge CLK);
        #1;
        cyc++;
        ea = qa.pop_front();
        eb = qb.pop_front();
        checks++;
        if ({a_valid, a_oor, perr[0], a_dout} !== ea) begin
            errors++;
            $display("FAIL port_a cyc=%0d got v=%b oor=%b perr=%b d=%h want v=%b oor=%b perr=%b d=%h",
                     cyc, a_valid, a_oor, perr[0], a_dout, ea.v, ea.o, ea.p, ea.d);
        end
        checks++;
        if ({b_valid, b_oor, perr[1], b_dout} !== eb) begin
            errors++;
            $display("FAIL port_b cyc=%0d got v=%b oor=%b perr=%b d=%h want v=%b oor=%b perr=%b d=%h",
                     cyc, b_valid, b_oor, perr[1], b_dout, eb.v, eb.o, eb.p, eb.d);
        end
    endtask

    task automatic op(input logic ae, input logic [3:0] awe, input logic [12:0] aad, input logic [31:0] ad,
                      input logic be, input logic [3:0] bwe, input logic [12:0] bad_a, input logic [31:0] bd);
        a_en = ae; a_we = awe; a_addr = aad; a_din = ad;
        b_en = be; b_we = bwe; b_addr = bad_a; b_din = bd;
        tick();
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < int'(READ_LAT) + 1; i++) tick();
    endtask

    task automatic test_reset();
        set_idle();
        RST = 1'b1;
        #13;
        checks++;
        if ({a_dout, b_dout} !== {IDLE_W, IDLE_W}) begin
            errors++;
            $display("FAIL reset_dout got a=%0d b=%0d want %0d", a_dout, b_dout, IDLE_W);
        end
        checks++;
        if ({a_valid, b_valid, a_oor, b_oor, perr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {a_valid, b_valid, a_oor, b_oor, perr});
        end
        checks++;
        if ({clr_busy, clr_done, b_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_clr got busy/done/ready=%b want 001", {clr_busy, clr_done, b_ready});
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        reset_queues();
    endtask

    task automatic test_preload();
        for (int i = 0; i < int'(DEPTH); i++) op(1, 4'hF, 13'(i), $urandom, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_basic_rw();
        op(1, 4'hF, 13'd33, 32'hA5A5_A5A5, 0, 0, 0, 0);
        op(1, 4'h0, 13'd33, 0, 0, 0, 0, 0);
        set_idle();
        tick();
        tick();
        op(1, 4'h0, 13'd33, 0, 0, 0, 0, 0);
        op(1, 4'h0, 13'd34, 0, 1, 4'h0, 13'd33, 0);
        drain();
    endtask

    task automatic test_collision();
        op(1, 4'b0011, 13'd5, 32'h1111_1111, 1, 4'b1110, 13'd5, 32'h2222_2222);
        op(1, 4'h0, 13'd5, 0, 1, 4'h0, 13'd5, 0);
        op(1, 4'hF, 13'd7, 32'hCAFE_0007, 1, 4'h0, 13'd7, 0);
        op(1, 4'h0, 13'd6, 0, 1, 4'hF, 13'd6, 32'h0BAD_0006);
        op(0, 0, 0, 0, 1, 4'h0, 13'd6, 0);
        drain();
    endtask

    task automatic test_oor();
        op(0, 0, 0, 0, 1, 4'h0, 13'd70, 0);
        op(1, 4'hF, 13'd70, 32'hDEAD_BEEF, 1, 4'hF, 13'd8191, 32'h1234_5678);
        op(1, 4'h0, 13'd6, 0, 1, 4'h0, 13'd64, 0);
        op(1, 4'h0, 13'd63, 0, 1, 4'h0, 13'd6, 0);
        drain();
    endtask

    task automatic test_clear();
        int busy_cycles;
        bit done_seen;
        op(1, 4'hF, 13'd32, 32'd777, 1, 4'hF, 13'd49, 32'd777);
        for (int i = 33; i <= 48; i++) op(1, 4'hF, 13'(i), $urandom | 32'h1, 0, 0, 0, 0);
        drain();
        clr_start = 1; clr_base = 13'd33; clr_len = 13'd16;
        @(posedge CLK);
        #1;
        clr_start = 0;
        b_en = 1; b_we = 4'hF; b_addr = 13'd40; b_din = 32'hDEAD_0040;
        busy_cycles = 0;
        done_seen = 0;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            if (clr_busy === 1'b1) begin
                busy_cycles++;
                checks++;
                if (b_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_ready k=%0d got b_ready=%b want 0", k, b_ready);
                end
            end
            if (clr_done === 1'b1) begin
                done_seen = 1;
                b_en = 0;
                checks++;
                if ({clr_busy, b_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL clear_done_state got busy/ready=%b want 01", {clr_busy, b_ready});
                end
            end else begin
                @(posedge CLK);
                #1;
            end
        end
        set_idle();
        checks++;
        if (!done_seen || busy_cycles != 16) begin
            errors++;
            $display("FAIL clear_len got busy_cycles=%0d done=%0d want 16 1", busy_cycles, done_seen);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (clr_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse got clr_done=%b want 0", clr_done);
        end
        for (int k = 0; k < 16; k++) begin
            mdl[(33 + k) % DEPTH] = 32'h0;
            bad[(33 + k) % DEPTH] = 4'h0;
        end
        for (int i = 32; i <= 49; i++) op(1, 4'h0, 13'(i), 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_clear_wrap();
        clr_start = 1; clr_base = 13'd62; clr_len = 13'd4;
        @(posedge CLK);
        #1;
        set_idle();
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            mdl[(62 + k) % DEPTH] = 32'h0;
            bad[(62 + k) % DEPTH] = 4'h0;
        end
        for (int i = 0; i < 3; i++) op(1, 4'h0, 13'(i), 0, 1, 4'h0, 13'(61 + i), 0);
        drain();
    endtask

    task automatic test_reset_mid_clear();
        bit saw_done;
        clr_start = 1; clr_base = 13'd50; clr_len = 13'd10;
        @(posedge CLK);
        #1;
        clr_start = 0;
        a_en = 1; a_we = 0; a_addr = 13'd1;
        @(posedge CLK);
        #1;
        set_idle();
        RST = 1'b1;
        #1;
        checks++;
        if ({clr_busy, clr_done, a_valid, b_ready} !== 4'b0001 || a_dout !== IDLE_W) begin
            errors++;
            $display("FAIL mid_clear_reset got busy/done/valid/ready=%b dout=%0d want 0001 %0d",
                     {clr_busy, clr_done, a_valid, b_ready}, a_dout, IDLE_W);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        saw_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            #1;
            if (clr_done === 1'b1 || clr_busy === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done got activity=1 want 0");
        end
        reset_queues();
        for (int i = 50; i < 60; i++) op(1, 4'hF, 13'(i), $urandom, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_zero_len();
        clr_start = 1; clr_base = 13'd10; clr_len = 13'd0;
        @(posedge CLK);
        #1;
        clr_start = 0;
        checks++;
        if ({clr_done, clr_busy, b_ready} !== 3'b101) begin
            errors++;
            $display("FAIL zero_len_pulse got done/busy/ready=%b want 101", {clr_done, clr_busy, b_ready});
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({clr_done, clr_busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_len_after got done/busy=%b want 00", {clr_done, clr_busy});
        end
    endtask

    task automatic test_parity();
`ifdef SIMD_BRAM_PARITY_EN
        dut.mem[10] = dut.mem[10] ^ 32'h0000_0100;
        mdl[10] = mdl[10] ^ 32'h0000_0100;
        bad[10][1] = 1'b1;
`endif
        op(1, 4'h0, 13'd10, 0, 1, 4'h0, 13'd10, 0);
        op(1, 4'h0, 13'd11, 0, 1, 4'h0, 13'd70, 0);
        op(1, 4'h2, 13'd10, 32'h0000_5A00, 0, 0, 0, 0);
        op(1, 4'h0, 13'd10, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_random();
        logic [12:0] aa, ba;
        for (int n = 0; n < 400; n++) begin
            aa = ($urandom_range(0, 9) < 8) ? 13'($urandom_range(0, 7)) : 13'($urandom_range(60, 69));
            ba = ($urandom_range(0, 9) < 8) ? 13'($urandom_range(0, 7)) : 13'($urandom_range(60, 69));
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom), aa, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom), ba, $urandom);
        end
        drain();
    endtask

    initial begin
        set_idle();
        for (int i = 0; i < int'(DEPTH); i++) begin
            mdl[i] = 32'h0;
            bad[i] = 4'h0;
        end
        test_reset();
        test_preload();
        test_basic_rw();
        test_collision();
        test_oor();
        test_clear();
        test_clear_wrap();
        test_parity();
        test_random();
        test_reset_mid_clear();
        test_zero_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_bram_rf_dp.md
Name: simd_bram_rf_dp

Overview:
- Parametrised dual-port block-RAM register file for the SIMD core. It holds the operand matrices A and B and the result matrix C.
- Port A serves the SIMD datapath. Port B serves the host/BRAM-controller side.
- Adds the following: per-byte write enables, configurable read latency with a valid pipeline, out-of-range detection, write-collision arbitration, and a hardware clear engine. The clear engine zeroes the result region between jobs.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words.
- ADDR_W, 13, address width; must satisfy 2**ADDR_W >= DEPTH.
- READ_LAT, 2, read latency in cycles from en to dout/valid; legal range 1..4.
- READ_FIRST, 1, same-port read-during-write. 1 returns the old data; 0 returns the new data.
- IDLE_WORD, 32'd399, value driven on dout when valid is low.
- OOR_WORD, 32'd199, value returned for reads with addr >= DEPTH.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- a_en  in  1  port A request
- a_we  in  DATA_W/8  port A byte write enables
- a_addr  in  ADDR_W  port A word address
- a_din  in  DATA_W  port A write data
- a_dout  out  DATA_W  port A read data
- a_valid  out  1  port A read data valid
- a_oor  out  1  port A out-of-range flag, aligned with a_valid
- b_en, b_we, b_addr, b_din, b_dout, b_valid, b_oor  as port A, for port B
- b_ready  out  1  port B accepts requests; low while clearing
- clr_start  in  1  pulse: start the clear engine
- clr_base  in  ADDR_W  first word to clear
- clr_len  in  ADDR_W  number of words to clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when the clear completes
- perr  out  2  parity error, {B,A}, aligned with valid

Behaviour:
- Reset:
  - Clears all valid, oor, perr and pipeline registers.
  - dout = IDLE_WORD, clr_busy = 0, clr_done = 0, b_ready = 1, FSM = IDLE.
  - Memory contents are not reset.
  - Reset asserted mid-clear aborts the clear with no done pulse.
- Reads:
  - A read is any en accepted with we == 0.
  - dout and valid appear exactly READ_LAT cycles after acceptance; fully pipelined, one per cycle.
  - valid deasserts when there is no read in flight.
- Writes:
  - Accepted when en = 1 and we != 0. Byte i is written when we[i] = 1.
  - No read response is produced; valid stays 0 for that slot.
  - Same-port read-during-write returns data according to READ_FIRST.
- Out of range:
  - addr >= DEPTH: the write is dropped.
  - A read returns OOR_WORD with oor = 1 and valid = 1.
- Collisions (same address, same cycle):
  - Both ports write: port A wins on bytes both ports enable; non-overlapping bytes merge.
  - One port writes, the other reads: the reader gets old data.
- Clear FSM (IDLE -> CLEAR -> DONE -> IDLE):
  - IDLE: on clr_start with clr_len != 0, latch base and len, set clr_busy, go to CLEAR.
  - IDLE: clr_start with clr_len == 0 pulses clr_done the next cycle and never asserts busy.
  - CLEAR: writes zero to one word per cycle through the port B slot. b_ready = 0; b_en is ignored.
  - CLEAR: the address wraps from DEPTH-1 to 0 and words beyond DEPTH are skipped, but each still counts one cycle.
  - CLEAR: after len words, go to DONE.
  - DONE: clr_done = 1 for one cycle, busy drops, b_ready = 1, return to IDLE.
  - clr_start while busy is ignored.
  - Port A remains fully usable during a clear. A port A write colliding with the clear wins.

Optional Feature:
- Macro SIMD_BRAM_PARITY_EN.
- Defined:
  - Store one even-parity bit per byte, updated on the byte write.
  - Reads check parity; perr[x] = 1 with valid when any byte mismatches.
  - Clear writes correct parity.
  - Port OOR reads give perr = 0.
- Undefined:
  - No parity storage.
  - perr is tied to 2'b00.

Decomposition:
- Package simd_bram_pkg:
  - clr_state_t enum {CLR_IDLE, CLR_RUN, CLR_DONE}
  - default IDLE_WORD/OOR_WORD constants
  - BYTES_OF(DATA_W) helper
- Sub-module simd_bram_rd_pipe: READ_LAT-deep shift of {valid, oor, perr, data}. It is instantiated once per port.

Test Plan (DATA_W=32, DEPTH=64, READ_LAT=2):
- Write 0xA5A5_A5A5 to A[33], then read A[33] -> cycle 2 after the read: a_dout = 0xA5A5_A5A5, a_valid = 1 for one cycle. Back-to-back reads of 33 and 34 -> consecutive valid cycles.
- A writes 0x1111_1111 with we = 4'b0011 and B writes 0x2222_2222 with we = 4'b1110 to addr 5 in the same cycle -> read gives 0x2222_1111.
- Read B addr 70 -> b_dout = 199, b_oor = 1. Write to addr 70 leaves addr 6 unchanged.
- Preload 33..48 with nonzero data; clr_start with base = 33, len = 16:
  - clr_busy for 16 cycles, b_ready = 0, then clr_done pulse.
  - Reads of 33..48 return 0; 32 and 49 are unchanged (777).
- Mid-clear: assert RST -> busy = 0 and valid = 0 immediately, no clr_done. clr_start with len = 0 -> done pulse with busy never set.
- With SIMD_BRAM_PARITY_EN: force-flip a stored bit via a backdoor on addr 10, then read -> perr[0] = 1 with a_valid. Without the macro, perr stays 00.
